// File: rtl/intr_ctrl.sv
// Interrupt source for the CPU control FSM: synchronizes and edge-detects request
// lines, latches them as pending, and hands the lowest-index enabled source to the CPU.
module intr_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               int_taken,
  input  logic               mret_exec,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               clr_we,
  input  logic [NUM_SRC-1:0] clr_wdata,
  output logic               INTR,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] sync_reg [SYNC_STAGES];
  logic [NUM_SRC-1:0] prev_reg;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] mask_reg;
  logic [ID_W-1:0]    irq_id_reg;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] req_vec;
  logic [NUM_SRC-1:0] grant_onehot;
  logic [NUM_SRC-1:0] clear_bits;
  logic [ID_W-1:0]    grant_id;
  logic               grant_found;
  logic               req_any;
  logic               take;

  // Synchronizer chain followed by one history flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise    = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign req_vec = pending_reg & mask_reg;
  assign req_any = |req_vec;
  assign take    = (state_reg == REQ) && int_taken;

  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    grant_found  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_vec[i] && !grant_found) begin
        grant_found     = 1'b1;
        grant_onehot[i] = 1'b1;
        grant_id        = ID_W'(i);
      end
    end
  end

  // A newly detected edge wins over a software or grant clear in the same cycle
  always_comb begin
    clear_bits   = (clr_we ? clr_wdata : '0) | (take ? grant_onehot : '0);
    pending_next = (pending_reg & ~clear_bits) | rise;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pending_reg <= '0;
      mask_reg    <= '0;
      irq_id_reg  <= '0;
    end else begin
      pending_reg <= pending_next;
      if (mask_we) mask_reg <= mask_wdata;
      if (take) irq_id_reg <= grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_any) state_next = REQ;
      REQ: begin
        if (int_taken)     state_next = SERVICE;
        else if (!req_any) state_next = IDLE;
      end
      SERVICE: if (mret_exec) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state register, so INTR has no input-to-output path
  always_comb begin
    INTR       = (state_reg == REQ);
    in_service = (state_reg == SERVICE);
  end

  assign irq_id  = irq_id_reg;
  assign pending = pending_reg;
  assign mask    = mask_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: stimulus pushes cycle-tagged expected outputs into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] irq_in;
  logic       int_taken, mret_exec, mask_we, clr_we;
  logic [7:0] mask_wdata, clr_wdata;
  logic       INTR, in_service;
  logic [2:0] irq_id;
  logic [7:0] pending, mask;

  intr_ctrl dut (
    .clk(clk), .RST(RST), .irq_in(irq_in), .int_taken(int_taken), .mret_exec(mret_exec),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .clr_we(clr_we), .clr_wdata(clr_wdata),
    .INTR(INTR), .irq_id(irq_id), .in_service(in_service), .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic       intr;
    logic       svc;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] msk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs after the edge just taken
  task automatic expect_now(input string name, input logic intr, input logic svc,
                            input logic [2:0] id, input logic [7:0] pend, input logic [7:0] msk);
    exp_t e;
    e.cyc = cyc; e.name = name; e.intr = intr; e.svc = svc;
    e.id = id; e.pend = pend; e.msk = msk;
    sb.push_back(e);
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_we = 1'b1; mask_wdata = v;
    step();
    mask_we = 1'b0;
  endtask

  task automatic pulse_take();
    int_taken = 1'b1;
    step();
    int_taken = 1'b0;
  endtask

  task automatic pulse_mret();
    mret_exec = 1'b1;
    step();
    mret_exec = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: check missed, due cycle %0d, now %0d", e.name, e.cyc, cyc);
      end else if ({INTR, in_service, irq_id, pending, mask} !==
                   {e.intr, e.svc, e.id, e.pend, e.msk}) begin
        errors++;
        $display("FAIL %s: got intr=%b svc=%b id=%0d pend=%h mask=%h, want intr=%b svc=%b id=%0d pend=%h mask=%h",
                 e.name, INTR, in_service, irq_id, pending, mask,
                 e.intr, e.svc, e.id, e.pend, e.msk);
      end else begin
        $display("ok   %s: intr=%b svc=%b id=%0d pend=%h mask=%h",
                 e.name, INTR, in_service, irq_id, pending, mask);
      end
    end
  end

  initial begin
    RST = 1'b1; irq_in = '0; int_taken = 1'b0; mret_exec = 1'b0;
    mask_we = 1'b0; mask_wdata = '0; clr_we = 1'b0; clr_wdata = '0;
    step(); step();
    RST = 1'b0;
    expect_now("reset", 0, 0, 0, 8'h00, 8'h00);

    // Basic handshake on source 0
    write_mask(8'h01);
    irq_in[0] = 1'b1;
    step(); step();
    expect_now("t1_sync_wait", 0, 0, 0, 8'h00, 8'h01);
    step();
    expect_now("t1_pend", 0, 0, 0, 8'h01, 8'h01);
    step();
    expect_now("t1_intr", 1, 0, 0, 8'h01, 8'h01);
    pulse_take();
    expect_now("t1_take", 0, 1, 0, 8'h00, 8'h01);
    pulse_mret();
    expect_now("t1_mret", 0, 0, 0, 8'h00, 8'h01);
    irq_in[0] = 1'b0;

    // Priority: sources 5 and 2 together
    write_mask(8'hFF);
    irq_in[5] = 1'b1; irq_in[2] = 1'b1;
    step(); step(); step();
    expect_now("t2_pend", 0, 0, 0, 8'h24, 8'hFF);
    step();
    expect_now("t2_intr", 1, 0, 0, 8'h24, 8'hFF);
    pulse_take();
    expect_now("t2_take1", 0, 1, 2, 8'h20, 8'hFF);
    pulse_mret();
    expect_now("t2_mret1", 0, 0, 2, 8'h20, 8'hFF);
    step();
    expect_now("t2_reintr", 1, 0, 2, 8'h20, 8'hFF);
    pulse_take();
    expect_now("t2_take2", 0, 1, 5, 8'h00, 8'hFF);
    pulse_mret();
    expect_now("t2_mret2", 0, 0, 5, 8'h00, 8'hFF);
    irq_in[5] = 1'b0; irq_in[2] = 1'b0;
    step(); step(); step();

    // Masking
    write_mask(8'h00);
    expect_now("t3_mask0", 0, 0, 5, 8'h00, 8'h00);
    irq_in[3] = 1'b1;
    step(); step(); step();
    expect_now("t3_pend", 0, 0, 5, 8'h08, 8'h00);
    step();
    expect_now("t3_nointr", 0, 0, 5, 8'h08, 8'h00);
    write_mask(8'h08);
    expect_now("t3_unmask", 0, 0, 5, 8'h08, 8'h08);
    step();
    expect_now("t3_intr", 1, 0, 5, 8'h08, 8'h08);
    write_mask(8'h00);
    expect_now("t3_remask", 1, 0, 5, 8'h08, 8'h00);
    step();
    expect_now("t3_drop", 0, 0, 5, 8'h08, 8'h00);
    clr_we = 1'b1; clr_wdata = 8'h08;
    step();
    clr_we = 1'b0;
    expect_now("t3_clr", 0, 0, 5, 8'h00, 8'h00);
    irq_in[3] = 1'b0;

    // Set wins over clear on source 1
    irq_in[1] = 1'b1;
    step(); step();
    clr_we = 1'b1; clr_wdata = 8'h02;
    step();
    clr_we = 1'b0;
    expect_now("t4_collide", 0, 0, 5, 8'h02, 8'h00);
    write_mask(8'h02);
    expect_now("t4_mask", 0, 0, 5, 8'h02, 8'h02);
    step();
    expect_now("t4_intr", 1, 0, 5, 8'h02, 8'h02);
    pulse_take();
    expect_now("t4_take1", 0, 1, 1, 8'h00, 8'h02);

    // Source 4 arrives during service and waits for mret
    irq_in[4] = 1'b1;
    write_mask(8'h12);
    step(); step();
    expect_now("t4_svc_pend", 0, 1, 1, 8'h10, 8'h12);
    step();
    expect_now("t4_svc_hold", 0, 1, 1, 8'h10, 8'h12);
    pulse_mret();
    expect_now("t4_mret", 0, 0, 1, 8'h10, 8'h12);
    step();
    expect_now("t4_serve4", 1, 0, 1, 8'h10, 8'h12);
    pulse_take();
    expect_now("t4_take4", 0, 1, 4, 8'h00, 8'h12);
    pulse_mret();
    expect_now("t4_mret4", 0, 0, 4, 8'h00, 8'h12);
    irq_in[1] = 1'b0; irq_in[4] = 1'b0;

    // Stray pulses
    pulse_take();
    expect_now("t5_stray_take", 0, 0, 4, 8'h00, 8'h12);
    step(); step();
    irq_in[1] = 1'b1;
    step(); step(); step();
    expect_now("t5_pend", 0, 0, 4, 8'h02, 8'h12);
    step();
    expect_now("t5_intr", 1, 0, 4, 8'h02, 8'h12);
    pulse_mret();
    expect_now("t5_stray_mret", 1, 0, 4, 8'h02, 8'h12);
    pulse_take();
    expect_now("t5_take", 0, 1, 1, 8'h00, 8'h12);

    // Reset during service, with source 7 held high through reset
    RST = 1'b1; irq_in = 8'h80;
    step();
    expect_now("t5_rst", 0, 0, 0, 8'h00, 8'h00);
    step();
    RST = 1'b0;
    step(); step();
    expect_now("t5_held_wait", 0, 0, 0, 8'h00, 8'h00);
    step();
    expect_now("t5_held_pend", 0, 0, 0, 8'h80, 8'h00);

    step(); step();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never compared, due cycle %0d", e.name, e.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt source side of the CPU control FSM's interrupt handshake. Drives INTR into the control unit; consumes the int_taken and mret_exec pulses that come back from it.
- Synchronizes NUM_SRC asynchronous request lines and edge-detects them. Latches requests as pending, applies a mask, and grants the lowest-index enabled source.
- Holds off further requests until the handler returns with mret.
- Sits between the peripheral interrupt lines and the CPU control unit; mask and clear registers are written through the MMIO decode.

Parameters:
NUM_SRC, 8, number of interrupt request inputs (1..32)
SYNC_STAGES, 2, flip-flop synchronizer depth per input (>=2)
ID_W, $clog2(NUM_SRC) (min 1), width of irq_id

Ports:
clk  in  1  system clock
RST  in  1  synchronous reset, active-high
irq_in  in  NUM_SRC  asynchronous level request lines; a rising edge requests an interrupt
int_taken  in  1  one-cycle pulse from the control FSM INTERRUPT state
mret_exec  in  1  one-cycle pulse from the control FSM when mret executes
mask_we  in  1  write enable for the mask register
mask_wdata  in  NUM_SRC  new mask value (1 = enabled)
clr_we  in  1  write enable for the software pending-clear
clr_wdata  in  NUM_SRC  pending bits to clear (1 = clear)
INTR  out  1  interrupt request to the control FSM (registered)
irq_id  out  ID_W  index of the source granted at the last int_taken
in_service  out  1  high while a handler is running
pending  out  NUM_SRC  pending register, readable via MMIO
mask  out  NUM_SRC  mask register, readable via MMIO

Behaviour:
- Reset: on RST high at a clk edge, all of the following clear to 0: state=IDLE, INTR, irq_id, in_service, pending, mask, synchronizer and edge-history flops.
  - An input held high through reset registers as a rising edge after release.
  - RST mid-service aborts to IDLE; no mret is needed.
- Synchronizer/edge detect, per bit:
  - sync chain of SYNC_STAGES flops, then prev flop.
  - rise = sync_out & ~prev.
  - irq_in first sampled high at edge t0 -> pending bit set at edge t0+SYNC_STAGES -> INTR high after edge t0+SYNC_STAGES+1 (if enabled and IDLE).
  - Pulses shorter than one clk period may be lost; this is not required to work.
- Pending register, next value per bit: (pending & ~clear_bits) | rise.
  - clear_bits = (clr_we ? clr_wdata : 0) | grant_onehot when a grant occurs.
  - Set wins over clear when both occur in the same cycle.
- Mask: loaded from mask_wdata when mask_we is high. Masked sources still latch pending; they only do not request.
- req_any = |(pending & mask).
- grant = lowest index i with pending[i] & mask[i].
- FSM (three states):
  - IDLE: INTR=0, in_service=0. If req_any -> REQ.
  - REQ: INTR=1.
    - int_taken -> SERVICE: irq_id <= grant and the granted pending bit is cleared at the same edge.
    - Else if !req_any (masked or cleared by software) -> IDLE, with INTR dropping at that edge.
    - int_taken has priority over req_any dropping in the same cycle.
  - SERVICE: INTR=0, in_service=1. mret_exec -> IDLE. New edges still latch as pending and are served after return; no nesting.
- INTR and in_service are decoded from registered state only; no combinational path from any input to INTR.
- Ignored pulses:
  - int_taken in IDLE or SERVICE: no effect.
  - mret_exec in IDLE or REQ: no effect.
- int_taken and mret_exec high together: handled per the current state's rule only.
- Return-to-request timing: SERVICE->IDLE->REQ takes 2 edges minimum. INTR is low for at least one cycle after mret, so the control FSM cannot re-enter INTERRUPT before the fetch after mret.
- irq_id holds its value until the next grant.

Test Plan:
- Reset, mask=8'h01, irq_in[0] rises at edge t0:
  - pending=8'h01 after t0+2; INTR=1 after t0+3.
  - int_taken pulse -> next edge: in_service=1, INTR=0, irq_id=0, pending=0.
  - mret_exec -> IDLE.
- Priority: mask=8'hFF, irq_in[5] and irq_in[2] rise in the same cycle:
  - first int_taken gives irq_id=2 and pending=8'h20.
  - after mret, INTR reasserts 2 cycles later; second grant irq_id=5.
- Masking: mask=0, irq_in[3] rises:
  - pending=8'h08, INTR stays 0.
  - write mask=8'h08 -> INTR=1 the following edge.
  - write mask=0 while in REQ -> INTR=0 next edge, state IDLE.
- Set-vs-clear collision: clr_we with clr_wdata=8'h02 in the same cycle that the source-1 rise is detected -> pending[1]=1.
  - Also: a source-4 rise in SERVICE latches pending[4] and is served only after mret_exec.
- Stray pulses: int_taken in IDLE and mret_exec in REQ -> no state, irq_id or pending change.
  - RST asserted during SERVICE -> all outputs 0 next edge.
  - irq_in[7] held high through reset -> pending[7]=1 two edges after release.
